// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake bundle between an operation initiator and the ALU sequencer.
// master drives requests and consumes responses; slave is the sequencer side.
interface alu_op_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_zero;
  logic             rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Initiator-side front end for the datapath ALU: registers operands/select, captures the
// ALU result one cycle later, returns it over a response handshake and counts completions.
module alu_op_sequencer #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_op_sequencer_if.slave    bus,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [2:0]           alu_select,
  input  logic [WIDTH-1:0]     alu_y,
  input  logic                 alu_zero,
  output logic [CNT_WIDTH-1:0] op_count
);
  localparam int unsigned OP_W = 3;
  localparam logic [OP_W-1:0] OP_CMP = 3'b110;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t               state;
  state_t               state_n;
  logic [WIDTH-1:0]     alu_a_n;
  logic [WIDTH-1:0]     alu_b_n;
  logic [OP_W-1:0]      alu_select_n;
  logic [WIDTH-1:0]     rsp_y_n;
  logic                 rsp_zero_n;
  logic                 rsp_err_n;
  logic [CNT_WIDTH-1:0] op_count_n;
  logic                 illegal_op;

  // Only 0xx and the compare code 110 exist in the ALU.
  assign illegal_op = alu_select[2] && (alu_select != OP_CMP);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state and next-value decode
  always_comb begin
    state_n      = state;
    alu_a_n      = alu_a;
    alu_b_n      = alu_b;
    alu_select_n = alu_select;
    rsp_y_n      = bus.rsp_y;
    rsp_zero_n   = bus.rsp_zero;
    rsp_err_n    = bus.rsp_err;
    op_count_n   = op_count;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          alu_a_n      = bus.req_a;
          alu_b_n      = bus.req_b;
          alu_select_n = bus.req_op;
          state_n      = EXEC;
        end
      end
      EXEC: begin
        state_n = RESP;
        if (illegal_op) begin
          rsp_y_n    = '0;
          rsp_zero_n = 1'b0;
          rsp_err_n  = 1'b1;
        end else begin
          rsp_y_n    = alu_y;
          rsp_zero_n = alu_zero;
          rsp_err_n  = 1'b0;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          op_count_n = op_count + CNT_WIDTH'(1);
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered outputs; handshake flags are decoded from the next state so they track the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_select    <= '0;
      bus.rsp_y     <= '0;
      bus.rsp_zero  <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      op_count      <= '0;
    end else begin
      alu_a         <= alu_a_n;
      alu_b         <= alu_b_n;
      alu_select    <= alu_select_n;
      bus.rsp_y     <= rsp_y_n;
      bus.rsp_zero  <= rsp_zero_n;
      bus.rsp_err   <= rsp_err_n;
      bus.req_ready <= (state_n == IDLE);
      bus.rsp_valid <= (state_n == RESP);
      op_count      <= op_count_n;
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer driving a behavioural ALU model; the counter width is
// reduced so the wrap-around boundary is reachable in a short run.
module tb_alu_op_sequencer;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned RV_W  = 3 * WIDTH + 7 + CNT_W;
  localparam logic [RV_W-1:0] RV_EXP = {1'b1, {(RV_W-1){1'b0}}};

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.WIDTH(WIDTH)) bus ();

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_y;
  logic [2:0]       alu_select;
  logic             alu_zero;
  logic [CNT_W-1:0] op_count;

  alu_op_sequencer #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_select (alu_select),
    .alu_y      (alu_y),
    .alu_zero   (alu_zero),
    .op_count   (op_count)
  );

  // Behavioural ALU; unimplemented codes produce junk that must never reach the response
  always_comb begin
    alu_y    = '0;
    alu_zero = 1'b0;
    case (alu_select)
      3'b000:  alu_y = alu_a & alu_b;
      3'b001:  alu_y = alu_a | alu_b;
      3'b010:  alu_y = alu_a + alu_b;
      3'b011:  alu_y = alu_a - alu_b;
      3'b110:  alu_zero = (alu_a == alu_b);
      default: begin
        alu_y    = alu_a ^ alu_b ^ 32'hDEAD_BEEF;
        alu_zero = 1'b1;
      end
    endcase
    if (!alu_select[2]) alu_zero = (alu_y == '0);
  end

  int unsigned      n_checks = 0;
  int unsigned      n_fail   = 0;
  rsp_t             sb[$];
  logic [CNT_W-1:0] exp_count = '0;

  function automatic rsp_t expect_of(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
    rsp_t r;
    r = '0;
    case (op)
      3'b000:  r.y = a & b;
      3'b001:  r.y = a | b;
      3'b010:  r.y = a + b;
      3'b011:  r.y = a - b;
      3'b110:  r.zero = (a == b);
      default: r.err = 1'b1;
    endcase
    if (op[2] == 1'b0) r.zero = (r.y == '0);
    return r;
  endfunction

  function automatic logic [RV_W-1:0] reset_view();
    return {bus.req_ready, bus.rsp_valid, bus.rsp_y, bus.rsp_zero, bus.rsp_err,
            alu_a, alu_b, alu_select, op_count};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [2:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, output bit ok);
    int i;
    i = 0;
    while (!bus.req_ready && i < 20) begin
      step();
      i++;
    end
    ok = bus.req_ready;
    if (ok) begin
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      sb.push_back(expect_of(op, a, b));
      step();
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(output bit ok);
    int i;
    i = 0;
    while (!bus.rsp_valid && i < 20) begin
      step();
      i++;
    end
    ok = bus.rsp_valid;
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    exp_count++;
  endtask

  task automatic test_reset();
    n_checks++;
    if (reset_view() !== RV_EXP) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", reset_view(), RV_EXP);
    end
  endtask

  task automatic test_single_add();
    bit   ok;
    rsp_t exp;
    send_req(3'b010, 32'd5, 32'd7, ok);
    n_checks++;
    if (!ok || alu_select !== 3'b010 || alu_a !== 32'd5 || alu_b !== 32'd7 || bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL add_accept: ok=%0b sel=%b a=%0d b=%0d ready=%b want sel=010 a=5 b=7 ready=0",
               ok, alu_select, alu_a, alu_b, bus.req_ready);
    end
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_exec_valid: got %b want 0", bus.rsp_valid);
    end
    step();
    exp = sb.pop_front();
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || {bus.rsp_y, bus.rsp_zero, bus.rsp_err} !== exp) begin
      n_fail++;
      $display("FAIL add_rsp: valid=%b y=%h z=%b e=%b want valid=1 %h", bus.rsp_valid,
               bus.rsp_y, bus.rsp_zero, bus.rsp_err, exp);
    end
    handshake();
    n_checks++;
    if (op_count !== exp_count || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_done: count=%0d ready=%b valid=%b want count=%0d ready=1 valid=0",
               op_count, bus.req_ready, bus.rsp_valid, exp_count);
    end
  endtask

  task automatic test_ops();
    logic [2:0]       ops [9] = '{3'b011, 3'b000, 3'b001, 3'b110, 3'b110, 3'b101, 3'b100, 3'b111, 3'b010};
    logic [WIDTH-1:0] as  [9] = '{32'h0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h1234, 32'h1234, 32'd3,
                                  32'h55, 32'h0, 32'hFFFFFFFF};
    logic [WIDTH-1:0] bs  [9] = '{32'h1, 32'h0FF00FF0, 32'h0FF00FF0, 32'h1234, 32'h1235, 32'd4,
                                  32'hAA, 32'h0, 32'h1};
    bit   ok;
    bit   okr;
    rsp_t exp;
    for (int i = 0; i < 9; i++) begin
      send_req(ops[i], as[i], bs[i], ok);
      wait_rsp(okr);
      exp = (sb.size() > 0) ? sb.pop_front() : '0;
      n_checks++;
      if (!ok || !okr || {bus.rsp_y, bus.rsp_zero, bus.rsp_err} !== exp) begin
        n_fail++;
        $display("FAIL op_%0d_rsp: op=%b ok=%0b/%0b y=%h z=%b e=%b want y=%h z=%b e=%b", i, ops[i],
                 ok, okr, bus.rsp_y, bus.rsp_zero, bus.rsp_err, exp.y, exp.zero, exp.err);
      end
      handshake();
      n_checks++;
      if (op_count !== exp_count) begin
        n_fail++;
        $display("FAIL op_%0d_count: got %0d want %0d", i, op_count, exp_count);
      end
    end
  endtask

  task automatic test_backpressure();
    bit   ok;
    bit   okr;
    rsp_t exp;
    send_req(3'b010, 32'd100, 32'd23, ok);
    wait_rsp(okr);
    exp = sb.pop_front();
    bus.req_valid = 1'b1;
    bus.req_op    = 3'b000;
    bus.req_a     = 32'hAAAA;
    bus.req_b     = 32'hFFFF;
    sb.push_back(expect_of(3'b000, 32'hAAAA, 32'hFFFF));
    for (int c = 0; c < 10; c++) begin
      step();
      n_checks++;
      if (!ok || !okr || bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1 ||
          {bus.rsp_y, bus.rsp_zero, bus.rsp_err} !== exp || alu_a !== 32'd100 || alu_select !== 3'b010) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: ready=%b valid=%b y=%h a=%h sel=%b want ready=0 valid=1 y=%h a=64 sel=010",
                 c, bus.req_ready, bus.rsp_valid, bus.rsp_y, alu_a, alu_select, exp.y);
      end
    end
    handshake();
    n_checks++;
    if (bus.req_ready !== 1'b1 || alu_a !== 32'd100 || op_count !== exp_count) begin
      n_fail++;
      $display("FAIL bp_release: ready=%b a=%h count=%0d want ready=1 a=64 count=%0d",
               bus.req_ready, alu_a, op_count, exp_count);
    end
    step();
    bus.req_valid = 1'b0;
    n_checks++;
    if (alu_a !== 32'hAAAA || alu_b !== 32'hFFFF || alu_select !== 3'b000) begin
      n_fail++;
      $display("FAIL bp_next_accept: a=%h b=%h sel=%b want a=aaaa b=ffff sel=000", alu_a, alu_b, alu_select);
    end
    wait_rsp(okr);
    exp = sb.pop_front();
    n_checks++;
    if (!okr || {bus.rsp_y, bus.rsp_zero, bus.rsp_err} !== exp) begin
      n_fail++;
      $display("FAIL bp_next_rsp: y=%h z=%b e=%b want %h", bus.rsp_y, bus.rsp_zero, bus.rsp_err, exp);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    bit   ok;
    bit   okr;
    rsp_t exp;
    send_req(3'b001, 32'h9, 32'h6, ok);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (!ok || reset_view() !== RV_EXP) begin
      n_fail++;
      $display("FAIL reset_in_exec: got %h want %h", reset_view(), RV_EXP);
    end
    step();
    rst_n = 1'b1;
    sb.delete();
    exp_count = '0;
    send_req(3'b011, 32'h9, 32'h2, ok);
    step();
    n_checks++;
    if (!ok || bus.rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_reach_resp: valid=%b want 1", bus.rsp_valid);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (reset_view() !== RV_EXP) begin
      n_fail++;
      $display("FAIL reset_in_resp: got %h want %h", reset_view(), RV_EXP);
    end
    sb.delete();
    step();
    // Request already present when reset lifts must be taken on the very next edge
    rst_n         = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = 3'b010;
    bus.req_a     = 32'h10;
    bus.req_b     = 32'h20;
    sb.push_back(expect_of(3'b010, 32'h10, 32'h20));
    step();
    bus.req_valid = 1'b0;
    n_checks++;
    if (alu_select !== 3'b010 || alu_a !== 32'h10 || bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_edge_accept: sel=%b a=%h ready=%b want sel=010 a=10 ready=0",
               alu_select, alu_a, bus.req_ready);
    end
    wait_rsp(okr);
    exp = sb.pop_front();
    n_checks++;
    if (!okr || {bus.rsp_y, bus.rsp_zero, bus.rsp_err} !== exp) begin
      n_fail++;
      $display("FAIL reset_after_rsp: y=%h want %h", bus.rsp_y, exp.y);
    end
    handshake();
    n_checks++;
    if (op_count !== exp_count) begin
      n_fail++;
      $display("FAIL reset_after_count: got %0d want %0d", op_count, exp_count);
    end
  endtask

  task automatic test_back_to_back();
    localparam int unsigned FULL = (1 << CNT_W) - 1;
    rst_n = 1'b0;
    #1;
    step();
    rst_n         = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = 3'b010;
    bus.req_a     = 32'h1;
    bus.req_b     = 32'h1;
    bus.rsp_ready = 1'b1;
    repeat (3 * 10) step();
    n_checks++;
    if (op_count !== CNT_W'(10)) begin
      n_fail++;
      $display("FAIL b2b_throughput: got %0d want 10", op_count);
    end
    repeat (3 * (FULL - 10)) step();
    n_checks++;
    if (op_count !== CNT_W'(FULL)) begin
      n_fail++;
      $display("FAIL b2b_all_ones: got %0d want %0d", op_count, FULL);
    end
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_y !== 32'h2) begin
      n_fail++;
      $display("FAIL b2b_idle_after: ready=%b y=%h want ready=1 y=2", bus.req_ready, bus.rsp_y);
    end
    repeat (3) step();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    n_checks++;
    if (op_count !== '0) begin
      n_fail++;
      $display("FAIL b2b_wrap: got %0d want 0", op_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    test_reset();
    test_single_add();
    test_ops();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
